// File: rtl/fir_out_framer.sv
// fir_out_framer: buffers FIR output in a FIFO and re-emits it as frames delimited by tlast.
// Define FIR_FRAMER_CHECKSUM_EN for a running wrap-around sum of the samples accepted in each frame.
module fir_out_framer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pFIFO_DEPTH = 8,
  parameter int pLEN_WIDTH  = 16
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst_n,
  input  logic                           cfg_start,
  input  logic [pLEN_WIDTH-1:0]          cfg_len,
  output logic                           busy,
  output logic                           done,
  input  logic                           s_tvalid,
  input  logic [pDATA_WIDTH-1:0]         s_tdata,
  output logic                           s_tready,
  output logic                           m_tvalid,
  output logic [pDATA_WIDTH-1:0]         m_tdata,
  output logic                           m_tlast,
  input  logic                           m_tready,
  output logic [$clog2(pFIFO_DEPTH):0]   fifo_count,
  output logic [pLEN_WIDTH-1:0]          sample_cnt,
  output logic [pDATA_WIDTH-1:0]         chk_sum
);
  localparam int AW = $clog2(pFIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [pDATA_WIDTH:0] mem [pFIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [pLEN_WIDTH-1:0] len_r;
  logic push, pop, full, empty, last_flag, start_ok, done_nx;
  assign full = fifo_count == (AW+1)'(pFIFO_DEPTH);
  assign empty = fifo_count == '0;
  assign last_flag = sample_cnt == len_r - pLEN_WIDTH'(1);
  assign s_tready = state == RUN && !full && sample_cnt < len_r;
  assign push = s_tvalid && s_tready;
  assign m_tvalid = !empty;
  assign pop = m_tvalid && m_tready;
  assign {m_tlast, m_tdata} = empty ? '0 : mem[rp];
  assign start_ok = state == IDLE && cfg_start && cfg_len != '0;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    state_nx = start_ok ? RUN :
               (state == RUN && push && last_flag) ? DRAIN :
               (state == DRAIN && pop && m_tlast) ? IDLE : state;
    done_nx = (state == IDLE && cfg_start && cfg_len == '0) || (state == DRAIN && pop && m_tlast);
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      len_r <= '0;
      sample_cnt <= '0;
    end else begin
      state <= state_nx;
      done <= done_nx;
      if (start_ok) begin
        len_r <= cfg_len;
        sample_cnt <= '0;
      end else if (push) sample_cnt <= sample_cnt + pLEN_WIDTH'(1);
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (push != pop) fifo_count <= push ? fifo_count + (AW+1)'(1) : fifo_count - (AW+1)'(1);
    end
  // Storage is not reset; reads are masked to zero while the FIFO is empty.
  always_ff @(posedge axis_clk)
    if (push) mem[wp] <= {last_flag, s_tdata};
`ifdef FIR_FRAMER_CHECKSUM_EN
  logic [pDATA_WIDTH-1:0] sum_r;
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) sum_r <= '0;
    else if (start_ok) sum_r <= '0;
    else if (push) sum_r <= sum_r + s_tdata;
  assign chk_sum = sum_r;
`else
  assign chk_sum = '0;
`endif
endmodule

// File: tb/tb_fir_out_framer.sv
// tb_fir_out_framer: directed frames with a scoreboard of expected {tlast, data} checked by a monitor.
module tb_fir_out_framer;
  logic axis_clk = 1'b0;
  logic axis_rst_n;
  logic cfg_start;
  logic [15:0] cfg_len;
  logic busy, done;
  logic s_tvalid, s_tready;
  logic [31:0] s_tdata;
  logic m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [3:0] fifo_count;
  logic [15:0] sample_cnt;
  logic [31:0] chk_sum;
  logic [32:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int d0;

  fir_out_framer #(.pDATA_WIDTH(32), .pFIFO_DEPTH(8), .pLEN_WIDTH(16)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .fifo_count(fifo_count), .sample_cnt(sample_cnt), .chk_sum(chk_sum)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len);
    cfg_start = 1'b1;
    cfg_len = len;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    int t = 0;
    exp_q.push_back({last, data});
    s_tvalid = 1'b1;
    s_tdata = data;
    while (!s_tready && t < 200) begin
      tick();
      t++;
    end
    if (t == 200) check("send_timeout", 64'(s_tready), 64'd1);
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      tick();
      t++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  always @(negedge axis_clk)
    if (axis_rst_n) begin
      if (done) done_cnt++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) check("sb_underflow", {31'd0, m_tlast, m_tdata}, 64'hdead);
        else check("sb_data", {31'd0, m_tlast, m_tdata}, {31'd0, exp_q.pop_front()});
      end
    end

  initial begin
    axis_rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_len = '0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    m_tready = 1'b0;
    tick();
    tick();
    check("rst_outputs", {busy, done, s_tready, m_tvalid, m_tlast, m_tdata}, 64'd0);
    check("rst_counts", {fifo_count, sample_cnt, chk_sum}, 64'd0);
    axis_rst_n = 1'b1;
    tick();
    // basic frame of four
    m_tready = 1'b1;
    start(16'd4);
    check("busy_run", 64'(busy), 64'd1);
    for (int i = 1; i <= 4; i++) send(32'(i), i == 4);
    wait_done();
`ifdef FIR_FRAMER_CHECKSUM_EN
    check("chk_sum_basic", 64'(chk_sum), 64'd10);
`else
    check("chk_sum_basic", 64'(chk_sum), 64'd0);
`endif
    check("sample_cnt_basic", 64'(sample_cnt), 64'd4);
    tick();
    check("done_single", 64'(done), 64'd0);
    // backpressure until full, then simultaneous push/pop at full
    m_tready = 1'b0;
    start(16'd12);
    for (int i = 1; i <= 8; i++) send(32'(100 + i), 1'b0);
    check("full_count", 64'(fifo_count), 64'd8);
    check("full_tready", 64'(s_tready), 64'd0);
    check("hold_head", {m_tvalid, m_tdata}, {31'd0, 1'b1, 32'd101});
    s_tvalid = 1'b1;
    s_tdata = 32'd109;
    tick();
    check("full_no_push", {fifo_count, sample_cnt}, {44'd0, 4'd8, 16'd8});
    exp_q.push_back({1'b0, 32'd109});
    m_tready = 1'b1;
    tick();
    check("pop_at_full", {fifo_count, sample_cnt}, {44'd0, 4'd7, 16'd8});
    tick();
    check("push_pop_same", {fifo_count, sample_cnt}, {44'd0, 4'd7, 16'd9});
    s_tvalid = 1'b0;
    for (int i = 10; i <= 12; i++) send(32'(100 + i), i == 12);
    wait_done();
    tick();
    // zero-length start
    start(16'd0);
    check("zero_len_done", {done, busy, s_tready}, 64'b100);
    tick();
    check("zero_len_single", {done, busy}, 64'd0);
    // start during RUN must not reload the length
    start(16'd3);
    send(32'd201, 1'b0);
    start(16'd99);
    send(32'd202, 1'b0);
    send(32'd203, 1'b1);
    wait_done();
    check("ignored_start_cnt", 64'(sample_cnt), 64'd3);
    tick();
    // reset mid-frame
    m_tready = 1'b0;
    start(16'd6);
    for (int i = 1; i <= 3; i++) send(32'(300 + i), 1'b0);
    d0 = done_cnt;
    axis_rst_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, s_tready, m_tvalid, m_tlast, m_tdata}, 64'd0);
    check("midrst_counts", {fifo_count, sample_cnt, chk_sum}, 64'd0);
    exp_q.delete();
    tick();
    axis_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_no_done", 64'(done_cnt), 64'(d0));
    m_tready = 1'b1;
    start(16'd2);
    send(32'd401, 1'b0);
    send(32'd402, 1'b1);
    wait_done();
    tick();
    // back-to-back frames: restart in the done cycle
    start(16'd3);
    for (int i = 1; i <= 3; i++) send(32'(500 + i), i == 3);
    wait_done();
    cfg_start = 1'b1;
    cfg_len = 16'd2;
    tick();
    cfg_start = 1'b0;
    check("b2b_restart", {done, busy}, 64'b01);
    send(32'd601, 1'b0);
    send(32'd602, 1'b1);
    wait_done();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
